sdram_request_queue: RTL and testbench
======================================

# sdram_request_queue

Buffered request front-end that sits directly upstream of the Max10 SDRAM controller. It accepts read/write requests from a client through a valid/ready handshake and holds them in a small FIFO. It issues them one at a time to the controller's single-pulse `inputValid` / `isBusy` / `recievedCommand` / `outputValid` interface and returns read data on a registered response port. The client never has to track controller busy periods, refresh stalls or acceptance timing.

## Interface
Parameters:
- `QUEUE_DEPTH`, default 4: FIFO entries; must be a power of two, at least 2.
- `ACCEPT_TIMEOUT`, default 8: cycles to wait for `recievedCommand` before re-issuing a request.

Ports:
- `activeClock`  in  1: controller clock, 143 MHz; the same clock that drives the controller.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: client request present.
- `req_ready`  out  1: queue can accept; equals `!full`.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_address`  in  25: bank[24:23], row[22:10], column[9:0].
- `req_data`  in  16: write data.
- `rsp_valid`  out  1: one-cycle pulse, read data valid.
- `rsp_data`  out  16: read data, held until the next `rsp_valid`.
- `rsp_address`  out  25: address of the returned read.
- `sdram_address`  out  25: to controller `address`.
- `sdram_inputData`  out  16: to controller `inputData`.
- `sdram_isWriting`  out  1: to controller `isWriting`.
- `sdram_inputValid`  out  1: to controller `inputValid`.
- `sdram_outputData`  in  16: from controller; valid only while `sdram_outputValid` is high.
- `sdram_outputValid`  in  1: controller read-complete pulse.
- `sdram_isBusy`  in  1: controller busy, either command or auto-refresh.
- `sdram_recievedCommand`  in  1: controller acceptance flag.
- `queue_count`  out  $clog2(QUEUE_DEPTH)+1: current FIFO occupancy.
- `verify_error`  out  1: sticky write-verify mismatch flag.

## Operation
- **Enqueue:** a request is pushed on any edge where `req_valid && req_ready` is true. Each entry is stored as {write, address, data}.
- **FSM states:** IDLE, ISSUE, WAIT_ACCEPT, WAIT_READ, WAIT_WRITE, plus VERIFY_ISSUE and VERIFY_WAIT when verify is enabled.
- **IDLE:** if the queue is non-empty and `!sdram_isBusy`, pop the head, register it onto the `sdram_*` outputs and go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** drive `sdram_inputValid` = 1 for exactly one cycle, clear the timeout counter, then go to WAIT_ACCEPT.
- **WAIT_ACCEPT:**
  - When `sdram_recievedCommand` is seen, go to WAIT_READ for a read or WAIT_WRITE for a write.
  - If the counter reaches `ACCEPT_TIMEOUT` first (for example, a refresh took the slot), return to ISSUE with the same registered request. The request is not lost and not reordered.
- **WAIT_READ:** on `sdram_outputValid`, capture `sdram_outputData` in that same cycle, pulse `rsp_valid` on the next cycle, then go to IDLE.
- **WAIT_WRITE:** once `sdram_isBusy` is low, go to IDLE, or to VERIFY_ISSUE when verify is enabled.
- **Ordering:** strictly one request outstanding; completion order equals request order.
- **Simultaneous events:**
  - Push and pop in the same cycle leave `queue_count` unchanged.
  - A push while full is impossible because `req_ready` is low.
- **Pointers:** FIFO pointers are `$clog2(QUEUE_DEPTH)`-bit and wrap naturally. Full/empty are derived from `queue_count`.

## Timing
- **Reset values:** `req_ready` = 1; `rsp_valid`, `sdram_inputValid`, `sdram_isWriting`, `verify_error` = 0; `queue_count`, `rsp_data`, `rsp_address`, `sdram_address`, `sdram_inputData` = 0; FSM in IDLE.
- **Reset mid-operation:** the queue is flushed and `sdram_inputValid` drops immediately. The controller is reset from the same source.
- **Issue latency:** a push at edge N into an empty queue, with the controller idle, gives `sdram_inputValid` high during cycle N+2.
- **Output stability:** `sdram_address`, `sdram_inputData` and `sdram_isWriting` are stable from ISSUE until the FSM returns to IDLE.
- **Read latency:** `rsp_valid` rises exactly one cycle after `sdram_outputValid`.

## Configuration
- `SDRAM_WRITE_VERIFY_EN` defined:
  - Every write is followed by a read of the same address (VERIFY_ISSUE, then VERIFY_WAIT, using the same accept/timeout rules).
  - A returned value that differs from the written data sets `verify_error`, which stays high until reset.
  - Verify reads never produce `rsp_valid`.
- Not defined: the VERIFY states are absent and `verify_error` is tied to 0.

## Structure
- **Shared package `sdram_pkg`:**
  - `sdram_req_t` struct: write, address[24:0], data[15:0].
  - FSM state enum.
  - Address field-slice constants: BANK_MSB/LSB, ROW_MSB/LSB, COL_MSB/LSB.
- **Sub-module `sdram_req_fifo`:** a parameterised synchronous FIFO of `sdram_req_t`, with push/pop/count/full/empty.

## Test plan
- **Write then read:** write 0xBEEF to 0x0123456, then read the same address. Required: `rsp_valid` pulses once with `rsp_data` = 0xBEEF and `rsp_address` = 0x0123456.
- **Fill to full:** push 4 writes with the controller model held busy. Required: `req_ready` = 0 and `queue_count` = 4; the writes drain in order once busy is released.
- **Refresh collision:** the controller model ignores the first `inputValid` and holds busy for 10 cycles. Required: a re-issue after 8 cycles, then exactly one accepted command and no duplicate response.
- **Reset mid-read:** assert `reset` during WAIT_READ. Required: all outputs at reset values next cycle, `queue_count` = 0, no `rsp_valid`.
- **Verify mismatch (`SDRAM_WRITE_VERIFY_EN`):** the model returns 0x0000 for a write of 0x55AA. Required: `verify_error` = 1 and sticky, with no `rsp_valid`.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM request front-end.
//   sdram_req_t : one queued request {write, address[24:0], data[15:0]}
//   state_t     : issue FSM states. VERIFY_* states exist only when
//                 SDRAM_WRITE_VERIFY_EN is defined.
//   BANK/ROW/COL_MSB/LSB : field positions inside the 25-bit address.
package sdram_pkg;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 16;

  localparam int BANK_MSB = 24;
  localparam int BANK_LSB = 23;
  localparam int ROW_MSB  = 22;
  localparam int ROW_LSB  = 10;
  localparam int COL_MSB  = 9;
  localparam int COL_LSB  = 0;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } sdram_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACCEPT,
    ST_WAIT_READ,
    ST_WAIT_WRITE
`ifdef SDRAM_WRITE_VERIFY_EN
    ,
    ST_VERIFY_ISSUE,
    ST_VERIFY_WAIT
`endif
  } state_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous FIFO of sdram_req_t entries.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (ignored while full)
//   pop      : drop the head entry (ignored while empty)
//   rdata    : current head entry (combinational read)
//   count    : occupancy, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  sdram_req_t             wdata,
  output sdram_req_t             rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  sdram_req_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sdram_request_queue.sv
// Buffered request front-end for the Max10 SDRAM controller.
// Client requests enter a FIFO via req_valid/req_ready and are issued one
// at a time on the controller's inputValid/isBusy/recievedCommand/outputValid
// interface; read data returns on a registered rsp_* port.
//   activeClock, reset        : controller clock, async active-high reset
//   req_valid/ready/write/address/data : client request handshake
//   rsp_valid/data/address    : one-cycle read response, data held
//   sdram_address/inputData/isWriting/inputValid : to controller
//   sdram_outputData/outputValid/isBusy/recievedCommand : from controller
//   queue_count               : FIFO occupancy
//   verify_error              : sticky write-verify mismatch
// Optional: define SDRAM_WRITE_VERIFY_EN to read back every write and
// compare; otherwise verify_error is tied low.
// A request not accepted is re-issued after ACCEPT_TIMEOUT cycles in
// WAIT_ACCEPT, so inputValid pulses are ACCEPT_TIMEOUT+1 cycles apart.
module sdram_request_queue
  import sdram_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned ACCEPT_TIMEOUT = 8
) (
  input  logic                         activeClock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [24:0]                  req_address,
  input  logic [15:0]                  req_data,
  output logic                         rsp_valid,
  output logic [15:0]                  rsp_data,
  output logic [24:0]                  rsp_address,
  output logic [24:0]                  sdram_address,
  output logic [15:0]                  sdram_inputData,
  output logic                         sdram_isWriting,
  output logic                         sdram_inputValid,
  input  logic [15:0]                  sdram_outputData,
  input  logic                         sdram_outputValid,
  input  logic                         sdram_isBusy,
  input  logic                         sdram_recievedCommand,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count,
  output logic                         verify_error
);

  localparam int unsigned TIMER_W = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(ACCEPT_TIMEOUT - 1);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  sdram_req_t         enq;
  sdram_req_t         head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  assign enq       = '{write: req_write, address: req_address, data: req_data};
  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;
  assign pop       = (state == ST_IDLE) && !fifo_empty && !sdram_isBusy;

  sdram_req_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (activeClock),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .wdata (enq),
    .rdata (head),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef SDRAM_WRITE_VERIFY_EN
  logic verify_accepted;
`else
  assign verify_error = 1'b0;
`endif

  always_ff @(posedge activeClock or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      timer            <= '0;
      sdram_address    <= '0;
      sdram_inputData  <= '0;
      sdram_isWriting  <= 1'b0;
      sdram_inputValid <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_address      <= '0;
`ifdef SDRAM_WRITE_VERIFY_EN
      verify_accepted  <= 1'b0;
      verify_error     <= 1'b0;
`endif
    end else begin
      sdram_inputValid <= 1'b0;
      rsp_valid        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            sdram_address   <= head.address;
            sdram_inputData <= head.data;
            sdram_isWriting <= head.write;
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          sdram_inputValid <= 1'b1;
          timer            <= '0;
          state            <= ST_WAIT_ACCEPT;
        end
        ST_WAIT_ACCEPT: begin
          if (sdram_recievedCommand) begin
            state <= sdram_isWriting ? ST_WAIT_WRITE : ST_WAIT_READ;
          end else if (timer == TIMEOUT_LAST) begin
            state <= ST_ISSUE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WAIT_READ: begin
          if (sdram_outputValid) begin
            rsp_data    <= sdram_outputData;
            rsp_address <= sdram_address;
            rsp_valid   <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_WAIT_WRITE: begin
          if (!sdram_isBusy) begin
`ifdef SDRAM_WRITE_VERIFY_EN
            state <= ST_VERIFY_ISSUE;
`else
            state <= ST_IDLE;
`endif
          end
        end
`ifdef SDRAM_WRITE_VERIFY_EN
        // Read-back reuses the held address and write data; only the
        // direction flips so the comparison has its reference on hand.
        ST_VERIFY_ISSUE: begin
          sdram_isWriting  <= 1'b0;
          sdram_inputValid <= 1'b1;
          timer            <= '0;
          verify_accepted  <= 1'b0;
          state            <= ST_VERIFY_WAIT;
        end
        // Acceptance and read return share one state: until accepted the
        // timeout rule applies, afterwards wait for the returned data.
        ST_VERIFY_WAIT: begin
          if (verify_accepted) begin
            if (sdram_outputValid) begin
              if (sdram_outputData != sdram_inputData) verify_error <= 1'b1;
              state <= ST_IDLE;
            end
          end else if (sdram_recievedCommand) begin
            verify_accepted <= 1'b1;
          end else if (timer == TIMEOUT_LAST) begin
            state <= ST_VERIFY_ISSUE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_request_queue.sv
// Self-checking bench for sdram_request_queue with a behavioural controller
// model. Expected read responses and expected write order are queued when
// requests are driven and compared when the DUT produces them.
// Build with SDRAM_WRITE_VERIFY_EN defined to exercise the verify path.
module tb_sdram_request_queue;
  import sdram_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [24:0] req_address = '0;
  logic [15:0] req_data = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [24:0] rsp_address;
  logic [24:0] sdram_address;
  logic [15:0] sdram_inputData;
  logic        sdram_isWriting;
  logic        sdram_inputValid;
  logic [15:0] sdram_outputData;
  logic        sdram_outputValid;
  logic        sdram_isBusy;
  logic        sdram_recievedCommand;
  logic [2:0]  queue_count;
  logic        verify_error;

  sdram_request_queue #(
    .QUEUE_DEPTH    (DEPTH),
    .ACCEPT_TIMEOUT (TIMEOUT)
  ) dut (
    .activeClock           (clk),
    .reset                 (reset),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_write             (req_write),
    .req_address           (req_address),
    .req_data              (req_data),
    .rsp_valid             (rsp_valid),
    .rsp_data              (rsp_data),
    .rsp_address           (rsp_address),
    .sdram_address         (sdram_address),
    .sdram_inputData       (sdram_inputData),
    .sdram_isWriting       (sdram_isWriting),
    .sdram_inputValid      (sdram_inputValid),
    .sdram_outputData      (sdram_outputData),
    .sdram_outputValid     (sdram_outputValid),
    .sdram_isBusy          (sdram_isBusy),
    .sdram_recievedCommand (sdram_recievedCommand),
    .queue_count           (queue_count),
    .verify_error          (verify_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboards
  sdram_req_t  rq[$];
  sdram_req_t  wq[$];
  logic [15:0] refmem [logic [24:0]];

  // Controller model state and knobs
  logic        hold_busy = 1'b0;
  logic        corrupt = 1'b0;
  int          ign_req = 0;
  int          ign_done = 0;
  int          busy_cnt = 0;
  int          rd_cnt = 0;
  logic [15:0] rd_val = '0;
  logic [15:0] mem [logic [24:0]];
  int          n_issue = 0;
  int          n_acc = 0;
  int          cyc = 0;
  int          iv_times[$];
  int          rsp_seen = 0;
  sdram_req_t  we;
  sdram_req_t  re;

  assign sdram_isBusy = (busy_cnt != 0) || hold_busy;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sdram_recievedCommand <= 1'b0;
      sdram_outputValid     <= 1'b0;
      sdram_outputData      <= 16'hDEAD;
      busy_cnt              <= 0;
      rd_cnt                <= 0;
    end else begin
      sdram_recievedCommand <= 1'b0;
      sdram_outputValid     <= 1'b0;
      sdram_outputData      <= 16'hDEAD;
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (rd_cnt != 0) begin
        rd_cnt <= rd_cnt - 1;
        if (rd_cnt == 1) begin
          sdram_outputValid <= 1'b1;
          sdram_outputData  <= rd_val;
        end
      end
      if (sdram_inputValid) begin
        n_issue++;
        iv_times.push_back(cyc);
        if (ign_req > ign_done) begin
          // Refresh steals the slot: command dropped, busy for 10 cycles.
          ign_done++;
          busy_cnt <= 10;
        end else if (busy_cnt == 0 && !hold_busy) begin
          n_acc++;
          sdram_recievedCommand <= 1'b1;
          busy_cnt <= 4;
          if (sdram_isWriting) begin
            mem[sdram_address] = corrupt ? 16'h0000 : sdram_inputData;
            if (wq.size() == 0) begin
              check("wr_extra", 1, 0);
            end else begin
              we = wq.pop_front();
              check("wr_addr", 64'(sdram_address), 64'(we.address));
              check("wr_data", 64'(sdram_inputData), 64'(we.data));
            end
          end else begin
            rd_cnt <= 3;
            rd_val <= mem.exists(sdram_address) ? mem[sdram_address] : 16'h0000;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_seen++;
      if (rq.size() == 0) begin
        check("rsp_extra", 1, 0);
      end else begin
        re = rq.pop_front();
        check("rsp_data", 64'(rsp_data), 64'(re.data));
        check("rsp_addr", 64'(rsp_address), 64'(re.address));
      end
    end
  end

  task automatic push_req(input logic w, input logic [24:0] a, input logic [15:0] d);
    int unsigned t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("push_ready_timeout", 64'(req_ready), 1);
    req_valid   = 1'b1;
    req_write   = w;
    req_address = a;
    req_data    = d;
    if (w) begin
      refmem[a] = d;
      wq.push_back('{write: 1'b1, address: a, data: d});
    end else begin
      rq.push_back('{write: 1'b0, address: a,
                     data: refmem.exists(a) ? refmem[a] : 16'h0000});
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base_i;
    int acc0;
    int rs0;
    logic [24:0] fill_addr [4];
    fill_addr[0] = 25'h0800010;
    fill_addr[1] = 25'h1000421;
    fill_addr[2] = 25'h1804832;
    fill_addr[3] = 25'h0000C43;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 1);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_input_valid", 64'(sdram_inputValid), 0);
    check("rst_is_writing", 64'(sdram_isWriting), 0);
    check("rst_verify_error", 64'(verify_error), 0);
    check("rst_queue_count", 64'(queue_count), 0);
    check("rst_outputs", {rsp_data, rsp_address}, 64'h0);
    check("rst_sdram_outputs", {sdram_inputData, sdram_address}, 64'h0);
    reset = 1'b0;
    drain(2);

    // Write then read, with issue latency of the first push
    rs0 = rsp_seen;
    push_req(1'b1, 25'h0123456, 16'hBEEF);
    k = 0;
    while (k < 8) begin
      @(negedge clk);
      k++;
      if (sdram_inputValid) break;
    end
    check("issue_latency", 64'(k), 3);
    push_req(1'b0, 25'h0123456, 16'h0);
    drain(60);
    check("wr_rd_rsp_count", 64'(rsp_seen - rs0), 1);
    check("wr_rd_pending", 64'(rq.size()), 0);

    // Fill to full with the controller held busy
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_req(1'b1, fill_addr[i], 16'(16'hA000 + i * 16'h0111));
    @(negedge clk);
    check("full_req_ready", 64'(req_ready), 0);
    check("full_queue_count", 64'(queue_count), 4);
    hold_busy = 1'b0;
    drain(160);
    check("fill_writes_drained", 64'(wq.size()), 0);
    check("fill_queue_empty", 64'(queue_count), 0);
    check("fill_req_ready", 64'(req_ready), 1);
    check("fill_verify_clean", 64'(verify_error), 0);
    rs0 = rsp_seen;
    for (int i = 0; i < 4; i++) push_req(1'b0, fill_addr[i], 16'h0);
    drain(80);
    check("fill_rsp_count", 64'(rsp_seen - rs0), 4);
    check("fill_rd_pending", 64'(rq.size()), 0);

    // Refresh collision: first inputValid dropped
    base_i = iv_times.size();
    acc0 = n_acc;
    rs0 = rsp_seen;
    ign_req = ign_req + 1;
    push_req(1'b0, 25'h0123456, 16'h0);
    drain(80);
    check("refresh_reissued", 64'(iv_times.size() - base_i >= 2), 1);
    if (iv_times.size() - base_i >= 2)
      check("refresh_gap", 64'(iv_times[base_i+1] - iv_times[base_i]), 64'(TIMEOUT + 1));
    check("refresh_accepts", 64'(n_acc - acc0), 1);
    check("refresh_rsp_count", 64'(rsp_seen - rs0), 1);

    // Reset during WAIT_READ with another request still queued
    rs0 = rsp_seen;
    push_req(1'b0, fill_addr[0], 16'h0);
    push_req(1'b0, fill_addr[1], 16'h0);
    k = 0;
    while (!sdram_recievedCommand && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("midread_accept_seen", 64'(sdram_recievedCommand), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    rq.delete();
    wq.delete();
    #1;
    check("midrst_queue_count", 64'(queue_count), 0);
    check("midrst_req_ready", 64'(req_ready), 1);
    check("midrst_valids", {rsp_valid, sdram_inputValid, sdram_isWriting}, 0);
    check("midrst_rsp", {rsp_data, rsp_address}, 64'h0);
    check("midrst_sdram", {sdram_inputData, sdram_address}, 64'h0);
    drain(2);
    reset = 1'b0;
    drain(30);
    check("midrst_no_rsp", 64'(rsp_seen - rs0), 0);
    check("midrst_queue_idle", 64'(queue_count), 0);

`ifdef SDRAM_WRITE_VERIFY_EN
    // Verify mismatch: model stores 0x0000 instead of 0x55AA
    rs0 = rsp_seen;
    corrupt = 1'b1;
    push_req(1'b1, 25'h0ABCDEF, 16'h55AA);
    drain(60);
    corrupt = 1'b0;
    check("verify_error_set", 64'(verify_error), 1);
    check("verify_no_rsp", 64'(rsp_seen - rs0), 0);
    push_req(1'b1, 25'h0000777, 16'h1234);
    drain(60);
    check("verify_error_sticky", 64'(verify_error), 1);
    check("verify_no_rsp_2", 64'(rsp_seen - rs0), 0);
`else
    push_req(1'b1, 25'h0ABCDEF, 16'h55AA);
    drain(40);
    check("verify_error_tied", 64'(verify_error), 0);
`endif
    check("final_writes_drained", 64'(wq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
